// File: rtl/core_pkg.sv
// Shared definitions for the core sequencer: opcodes, FSM state encoding,
// ALU operation codes and the opcode classification record.
package core_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;

  // Encoding 3'd7 is deliberately unnamed; the sequencer treats it as IDLE.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEMORY    = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_TRAP      = 3'd6
  } state_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  typedef struct packed {
    logic legal;
    logic is_mem;
    logic is_store;
    logic writes_rd;
  } op_class_t;

endpackage

// File: rtl/core_sequencer_if.sv
// Control/handshake bundle between the core sequencer and its surroundings.
interface core_sequencer_if;

  logic        start;
  logic        halt_req;
  logic [6:0]  OPERATION;
  logic        imem_ready;
  logic        dmem_ready;
  logic        imem_req;
  logic        dmem_req;
  logic        dmem_we;
  logic        ir_load;
  logic        pc_wr_en;
  logic        rf_wr_gate;
  logic [2:0]  state;
  logic        busy;
  logic        trap;
  logic [31:0] retired;

  modport master (
    output start, halt_req, OPERATION, imem_ready, dmem_ready,
    input  imem_req, dmem_req, dmem_we, ir_load, pc_wr_en, rf_wr_gate,
    input  state, busy, trap, retired
  );

  modport slave (
    input  start, halt_req, OPERATION, imem_ready, dmem_ready,
    output imem_req, dmem_req, dmem_we, ir_load, pc_wr_en, rf_wr_gate,
    output state, busy, trap, retired
  );

endinterface

// File: rtl/core_sequencer_classifier.sv
// Combinational opcode decode: legality, memory access, store and rd-write flags.
module opcode_classifier
  import core_pkg::*;
(
  input  logic [6:0] OPERATION,
  output op_class_t  cls
);

  always_comb begin
    cls = '0;
    case (OPERATION)
      OP_R, OP_I, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: begin
        cls.legal     = 1'b1;
        cls.writes_rd = 1'b1;
      end
      OP_LOAD: begin
        cls.legal     = 1'b1;
        cls.is_mem    = 1'b1;
        cls.writes_rd = 1'b1;
      end
      OP_STORE: begin
        cls.legal    = 1'b1;
        cls.is_mem   = 1'b1;
        cls.is_store = 1'b1;
      end
      OP_BRANCH: cls.legal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXECUTE/[MEMORY]/WRITEBACK
// with a sticky TRAP on illegal opcodes and a retired-instruction counter.
module core_sequencer
  import core_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  core_sequencer_if.slave  bus
);

  state_e      state_q, state_d;
  logic        trap_q, trap_d;
  logic [31:0] retired_q, retired_d;
  op_class_t   cls;

  logic imem_req, dmem_req, dmem_we, ir_load, pc_wr_en, rf_wr_gate;

  opcode_classifier u_classifier (
    .OPERATION (bus.OPERATION),
    .cls       (cls)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      trap_q    <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      trap_q    <= trap_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    trap_d     = trap_q;
    retired_d  = retired_q;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    ir_load    = 1'b0;
    pc_wr_en   = 1'b0;
    rf_wr_gate = 1'b0;
    case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_FETCH;
      ST_FETCH: begin
        imem_req = 1'b1;
        if (bus.imem_ready) begin
          ir_load = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: state_d = ST_EXECUTE;
      ST_EXECUTE: begin
        if (!cls.legal) begin
          state_d = ST_TRAP;
          trap_d  = 1'b1;
        end else if (cls.is_mem) begin
          state_d = ST_MEMORY;
        end else begin
          state_d = ST_WRITEBACK;
        end
      end
      ST_MEMORY: begin
        dmem_req = 1'b1;
        dmem_we  = cls.is_store;
        if (bus.dmem_ready) state_d = ST_WRITEBACK;
      end
      ST_WRITEBACK: begin
        pc_wr_en   = 1'b1;
        rf_wr_gate = cls.writes_rd;
        retired_d  = retired_q + 32'd1;
        state_d    = bus.halt_req ? ST_IDLE : ST_FETCH;
      end
      // Only reset leaves TRAP; every request stays low here.
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.imem_req   = imem_req;
  assign bus.dmem_req   = dmem_req;
  assign bus.dmem_we    = dmem_we;
  assign bus.ir_load    = ir_load;
  assign bus.pc_wr_en   = pc_wr_en;
  assign bus.rf_wr_gate = rf_wr_gate;
  assign bus.state      = state_q;
  assign bus.busy       = (state_q != ST_IDLE) && (state_q != ST_TRAP);
  assign bus.trap       = trap_q;
  assign bus.retired    = retired_q;

endmodule

// File: doc/core_sequencer.md
CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 The port clock SHALL be an input, 1 bit wide: the system clock; all state updates on its rising edge.
REQ-003 The port reset_n SHALL be an input, 1 bit wide: asynchronous active-low reset.
REQ-004 The port start SHALL be an input, 1 bit wide: begin instruction execution; sampled in IDLE only.
REQ-005 The port halt_req SHALL be an input, 1 bit wide: stop after the current instruction retires.
REQ-006 The port OPERATION SHALL be an input, 7 bits wide: opcode field from the decode stage (instruction[6:0]).
REQ-007 The port imem_ready SHALL be an input, 1 bit wide: instruction memory has returned data.
REQ-008 The port dmem_ready SHALL be an input, 1 bit wide: data memory access is complete.
REQ-009 The port imem_req SHALL be an output, 1 bit wide: instruction fetch request.
REQ-010 The port dmem_req SHALL be an output, 1 bit wide: data memory request.
REQ-011 The port dmem_we SHALL be an output, 1 bit wide: data memory write qualifier, valid with dmem_req.
REQ-012 The port ir_load SHALL be an output, 1 bit wide: one-cycle pulse that latches the fetched instruction.
REQ-013 The port pc_wr_en SHALL be an output, 1 bit wide: one-cycle pulse that updates the PC.
REQ-014 The port rf_wr_gate SHALL be an output, 1 bit wide: permits the register-file write (ANDed with RF_WR_EN outside this block).
REQ-015 The port state SHALL be an output, 3 bits wide: current FSM state encoding.
REQ-016 The port busy SHALL be an output, 1 bit wide: high in every state except IDLE and TRAP.
REQ-017 The port trap SHALL be an output, 1 bit wide: illegal opcode detected; sticky.
REQ-018 The port retired SHALL be an output, 32 bits wide: count of retired instructions.

Function
REQ-019 The FSM SHALL use states IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5 and TRAP=6; code 7 SHALL go to IDLE.
REQ-020 In IDLE, start=1 SHALL cause a move to FETCH on the next edge; otherwise the FSM stays in IDLE.
REQ-021 In FETCH, imem_req SHALL be high; on a cycle with imem_ready=1, ir_load SHALL pulse in that same cycle and the FSM moves to DECODE; otherwise it waits indefinitely.
REQ-022 DECODE SHALL last exactly one cycle and then move to EXECUTE.
REQ-023 EXECUTE SHALL last one cycle: OPERATION 0000011 or 0100011 goes to MEMORY; any other legal opcode goes to WRITEBACK; an illegal opcode goes to TRAP.
REQ-024 The legal opcodes SHALL be 0110011, 0010011, 1101111, 1100111, 0110111, 0010111, 1100011, 0100011 and 0000011.
REQ-025 In MEMORY, dmem_req SHALL be high and dmem_we SHALL equal (OPERATION==0100011); dmem_ready=1 moves the FSM to WRITEBACK; otherwise it waits.
REQ-026 WRITEBACK SHALL last one cycle and pulse pc_wr_en.
REQ-027 In WRITEBACK, rf_wr_gate SHALL be high for opcodes R, I, LOAD, JAL, JALR, LUI and AUIPC, and low for branch and store.
REQ-028 In WRITEBACK, retired SHALL increment by 1, wrapping from 0xFFFFFFFF to 0.
REQ-029 Leaving WRITEBACK, the FSM SHALL go to IDLE if halt_req=1 in that cycle, else to FETCH.
REQ-030 halt_req asserted earlier and then dropped SHALL have no effect.
REQ-031 In TRAP, trap SHALL be 1 and every request and pulse SHALL be 0; TRAP SHALL exit only by reset.
REQ-032 imem_req, dmem_req, dmem_we, ir_load, pc_wr_en and rf_wr_gate SHALL be combinational from state and inputs; state, trap and retired SHALL be registered.
REQ-033 imem_ready outside FETCH and dmem_ready outside MEMORY SHALL be ignored.
REQ-034 start outside IDLE SHALL be ignored.
REQ-035 Best-case latency SHALL be 4 cycles per non-memory instruction and 5 cycles per load or store (FETCH, DECODE, EXECUTE, [MEMORY], WRITEBACK).

Reset
REQ-036 While reset_n=0, the block SHALL immediately force state=IDLE, trap=0, retired=0 and all request and pulse outputs to 0, including when reset is asserted mid-FETCH or mid-MEMORY.
REQ-037 After reset_n rises, the block SHALL wait for start.

Structure
REQ-038 The opcode constants and the state encodings SHALL live in a shared package (core_pkg), alongside the ALU operation defines.
REQ-039 One sub-module, opcode_classifier, SHALL be used: combinational, OPERATION -> {legal, is_mem, is_store, writes_rd}.

Verification
REQ-040 The bench SHALL check: reset, start=1 and add (0110011) with imem_ready and dmem_ready tied to 1 -> states 1,2,3,5; pc_wr_en=1 and rf_wr_gate=1 in the cycle state=5; retired=1.
REQ-041 The bench SHALL check: sw (0100011) with dmem_ready delayed 3 cycles -> dmem_req=1 and dmem_we=1 for 4 cycles; rf_wr_gate=0 in WRITEBACK; retired increments.
REQ-042 The bench SHALL check: OPERATION=0001111 in EXECUTE -> state=6 and trap=1; start pulses are ignored; only reset_n=0 clears trap.
REQ-043 The bench SHALL check: halt_req=1 during WRITEBACK of a beq (1100011) -> next state=0, busy=0, rf_wr_gate=0.
REQ-044 The bench SHALL check: reset_n=0 asserted mid-MEMORY with dmem_req=1 -> dmem_req=0 and state=0 without waiting for a clock edge; retired=0.
REQ-045 The bench SHALL check: retired preloaded via force to 0xFFFFFFFF, then one instruction retires -> retired=0.
